// File: rtl/torreta_rx_relatorio_if.sv
// torreta_rx_relatorio_if: serial input plus decoded report outputs of the turret report receiver.
// master = line driver / display consumer side, slave = the receiver itself.
interface torreta_rx_relatorio_if;
    logic       entrada_serial;
    logic [3:0] angulo_centena;
    logic [3:0] angulo_dezena;
    logic [3:0] angulo_unidade;
    logic [3:0] distancia_centena;
    logic [3:0] distancia_dezena;
    logic [3:0] distancia_unidade;
    logic       quadro_valido;
    logic       erro_quadro;
    logic       ameaca;
    logic [3:0] db_estado;

    modport master (
        output entrada_serial,
        input  angulo_centena, angulo_dezena, angulo_unidade,
        input  distancia_centena, distancia_dezena, distancia_unidade,
        input  quadro_valido, erro_quadro, ameaca, db_estado
    );

    modport slave (
        input  entrada_serial,
        output angulo_centena, angulo_dezena, angulo_unidade,
        output distancia_centena, distancia_dezena, distancia_unidade,
        output quadro_valido, erro_quadro, ameaca, db_estado
    );
endinterface

// File: rtl/torreta_rx_relatorio.sv
// torreta_rx_relatorio: UART receiver and parser for turret reports "ccc,ddd#".
// Holds the last good angle/distance as BCD and flags distances below LIMIAR_CM.
// Define TORRETA_RX_PARIDADE_EN for 8E1 framing (even parity bit before the stop bit).
module torreta_rx_relatorio #(
    parameter int unsigned CLKS_POR_BIT = 5208,
    parameter int unsigned LIMIAR_CM    = 50
) (
    input logic                   clock,
    input logic                   reset,
    torreta_rx_relatorio_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(CLKS_POR_BIT);
    localparam logic [CntW-1:0] CntFim  = CntW'(CLKS_POR_BIT - 1);
    localparam logic [CntW-1:0] CntMeio = CntW'(CLKS_POR_BIT / 2 - 1);
    localparam logic [9:0]      Limiar  = 10'(LIMIAR_CM);

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxPar, RxStop, RxWaitHigh
    } rx_state_e;

    typedef enum logic [3:0] {
        StEspera = 4'd0,
        StA1     = 4'd1,
        StA2     = 4'd2,
        StVirg   = 4'd3,
        StD0     = 4'd4,
        StD1     = 4'd5,
        StD2     = 4'd6,
        StTerm   = 4'd7,
        StCommit = 4'd8
    } parse_state_e;

    // ---------------- receiver ----------------
    logic [1:0]      sync_q;
    logic            rx_prev_q;
    logic            rx;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_ok;
    logic            rx_err;
`ifdef TORRETA_RX_PARIDADE_EN
    logic            par_ok_q, par_ok_d;
`endif

    assign rx = sync_q[1];

    // Two-flop synchroniser; idle-high reset value avoids a false start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], bus.entrada_serial};
            rx_prev_q <= sync_q[1];
        end
    end

    // Receiver state and bit timing registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RxIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
`ifdef TORRETA_RX_PARIDADE_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
`ifdef TORRETA_RX_PARIDADE_EN
            par_ok_q   <= par_ok_d;
`endif
        end
    end

    // Receiver next state: start-edge detect, mid-bit sampling, stop/parity checks.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_ok    = 1'b0;
        rx_err     = 1'b0;
`ifdef TORRETA_RX_PARIDADE_EN
        par_ok_d   = par_ok_q;
`endif
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx) begin
                    rx_state_d = RxStart;
                    cnt_d      = '0;
                end
            end
            RxStart: begin
                if (cnt_q == CntMeio) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    // Line back high at mid start bit means a glitch.
                    rx_state_d = rx ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (cnt_q == CntFim) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef TORRETA_RX_PARIDADE_EN
                        rx_state_d = RxPar;
`else
                        rx_state_d = RxStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef TORRETA_RX_PARIDADE_EN
            RxPar: begin
                if (cnt_q == CntFim) begin
                    cnt_d      = '0;
                    par_ok_d   = ~(^{rx, shift_q});
                    rx_state_d = RxStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RxStop: begin
                if (cnt_q == CntFim) begin
                    cnt_d = '0;
                    if (!rx) begin
                        // Framing error: do not re-arm until the line idles high.
                        rx_err     = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end else begin
                        rx_state_d = RxIdle;
`ifdef TORRETA_RX_PARIDADE_EN
                        if (par_ok_q) begin
                            byte_ok = 1'b1;
                        end else begin
                            rx_err = 1'b1;
                        end
`else
                        byte_ok = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RxWaitHigh: begin
                if (rx) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- parser ----------------
    parse_state_e    p_state_q, p_state_d;
    logic [5:0][3:0] sombra_q, sombra_d;
    logic [5:0][3:0] saida_q;
    logic            erro_q;
    logic            ameaca_q;
    logic            commit;
    logic            erro_set;
    logic            eh_digito;
    logic [9:0]      dist_valor;

    assign eh_digito = (shift_q >= 8'h30) && (shift_q <= 8'h39);

    // Parser next state; shadow digits collect the frame until the terminator arrives.
    always_comb begin
        p_state_d = p_state_q;
        sombra_d  = sombra_q;
        commit    = 1'b0;
        erro_set  = 1'b0;
        if (rx_err) begin
            erro_set  = 1'b1;
            p_state_d = StEspera;
        end else if (byte_ok) begin
            unique case (p_state_q)
                StEspera: begin
                    if (eh_digito) begin
                        sombra_d[0] = shift_q[3:0];
                        p_state_d   = StA1;
                    end
                end
                StA1: begin
                    if (eh_digito) begin
                        sombra_d[1] = shift_q[3:0];
                        p_state_d   = StA2;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                StA2: begin
                    if (eh_digito) begin
                        sombra_d[2] = shift_q[3:0];
                        p_state_d   = StVirg;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                StVirg: begin
                    if (shift_q == 8'h2C) begin
                        p_state_d = StD0;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                StD0: begin
                    if (eh_digito) begin
                        sombra_d[3] = shift_q[3:0];
                        p_state_d   = StD1;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                StD1: begin
                    if (eh_digito) begin
                        sombra_d[4] = shift_q[3:0];
                        p_state_d   = StD2;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                StD2: begin
                    if (eh_digito) begin
                        sombra_d[5] = shift_q[3:0];
                        p_state_d   = StTerm;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                StTerm: begin
                    if (shift_q == 8'h23) begin
                        commit    = 1'b1;
                        p_state_d = StCommit;
                    end else begin
                        erro_set  = 1'b1;
                        p_state_d = StEspera;
                    end
                end
                default: p_state_d = StEspera;
            endcase
        end else if (p_state_q == StCommit) begin
            p_state_d = StEspera;
        end
    end

    assign dist_valor = {6'd0, saida_q[3]} * 10'd100 + {6'd0, saida_q[4]} * 10'd10
                      + {6'd0, saida_q[5]};

    // Parser state, shadow and committed digits, sticky error and threat flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_state_q <= StEspera;
            sombra_q  <= '0;
            saida_q   <= '0;
            erro_q    <= 1'b0;
            ameaca_q  <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            sombra_q  <= sombra_d;
            // Loaded on entry to COMMIT so all six digits change together with the pulse.
            if (commit) begin
                saida_q <= sombra_q;
            end
            if (commit) begin
                erro_q <= 1'b0;
            end else if (erro_set) begin
                erro_q <= 1'b1;
            end
            if (p_state_q == StCommit) begin
                ameaca_q <= (dist_valor < Limiar);
            end
        end
    end

    assign bus.angulo_centena    = saida_q[0];
    assign bus.angulo_dezena     = saida_q[1];
    assign bus.angulo_unidade    = saida_q[2];
    assign bus.distancia_centena = saida_q[3];
    assign bus.distancia_dezena  = saida_q[4];
    assign bus.distancia_unidade = saida_q[5];
    assign bus.quadro_valido     = (p_state_q == StCommit);
    assign bus.erro_quadro       = erro_q;
    assign bus.ameaca            = ameaca_q;
    assign bus.db_estado         = p_state_q;
endmodule

// File: tb/tb_torreta_rx_relatorio.sv
// Bench for torreta_rx_relatorio: serial frames in, committed digits/flags checked
// against a frame-level model (last good frame, threshold arithmetic).
module tb_torreta_rx_relatorio;
    localparam int Clks   = 16;
    localparam int Limiar = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    torreta_rx_relatorio_if bus ();

    torreta_rx_relatorio #(
        .CLKS_POR_BIT(Clks),
        .LIMIAR_CM   (Limiar)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: last committed frame and expected flags.
    int m_ang    = 0;
    int m_dist   = 0;
    bit m_erro   = 1'b0;
    bit m_ameaca = 1'b0;
    int m_qv     = 0;

    logic [11:0] ang_w, dist_w;
    assign ang_w  = {bus.angulo_centena, bus.angulo_dezena, bus.angulo_unidade};
    assign dist_w = {bus.distancia_centena, bus.distancia_dezena, bus.distancia_unidade};

    // Pulse monitor: counts commits, captures digits in the pulse cycle and ameaca around it.
    int          qv_count = 0;
    logic [11:0] ang_at_qv, dist_at_qv;
    logic        ameaca_at_qv, ameaca_after_qv;
    bit          capture_next = 1'b0;
    always @(negedge clk) begin
        if (capture_next) begin
            ameaca_after_qv = bus.ameaca;
            capture_next    = 1'b0;
        end
        if (bus.quadro_valido === 1'b1) begin
            qv_count++;
            ang_at_qv    = ang_w;
            dist_at_qv   = dist_w;
            ameaca_at_qv = bus.ameaca;
            capture_next = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bcd3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit eh_dig(input byte c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit frame_ok(input string s);
        if (s.len() != 8) return 1'b0;
        return eh_dig(s.getc(0)) && eh_dig(s.getc(1)) && eh_dig(s.getc(2)) &&
               (s.getc(3) == 8'h2C) && eh_dig(s.getc(4)) && eh_dig(s.getc(5)) &&
               eh_dig(s.getc(6)) && (s.getc(7) == 8'h23);
    endfunction

    function automatic int field(input string s, input int p);
        return (int'(s.getc(p)) - 48) * 100 + (int'(s.getc(p + 1)) - 48) * 10
             + (int'(s.getc(p + 2)) - 48);
    endfunction

    // mode: 0 normal, 1 stop bit forced low, 2 parity flipped
    task automatic send_byte(input logic [7:0] b, input int mode);
        bus.entrada_serial = 1'b0;
        repeat (Clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.entrada_serial = b[i];
            repeat (Clks) @(negedge clk);
        end
`ifdef TORRETA_RX_PARIDADE_EN
        bus.entrada_serial = (^b) ^ (mode == 2);
        repeat (Clks) @(negedge clk);
`endif
        bus.entrada_serial = (mode != 1);
        repeat (Clks) @(negedge clk);
        bus.entrada_serial = 1'b1;
    endtask

    task automatic send_frame(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s.getc(i), 0);
    endtask

    // Frames used are either well formed or have one position replaced by a letter.
    task automatic model_frame(input string s);
        if (frame_ok(s)) begin
            m_ang    = field(s, 0);
            m_dist   = field(s, 4);
            m_erro   = 1'b0;
            m_ameaca = (m_dist < Limiar);
            m_qv++;
        end else begin
            m_erro = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.entrada_serial = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ang_w, dist_w} !== 24'h0) begin
            errors++;
            $display("FAIL reset_digits: got %h required 000000", {ang_w, dist_w});
        end
        checks++;
        if ({bus.quadro_valido, bus.erro_quadro, bus.ameaca, bus.db_estado} !== 7'h0) begin
            errors++;
            $display("FAIL reset_flags: got qv=%b err=%b am=%b st=%0d required all 0",
                     bus.quadro_valido, bus.erro_quadro, bus.ameaca, bus.db_estado);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.db_estado !== 4'd0 || bus.ameaca !== 1'b0) begin
            errors++;
            $display("FAIL after_release: got st=%0d am=%b required 0 0",
                     bus.db_estado, bus.ameaca);
        end
    endtask

    task automatic test_basic();
        int q0 = qv_count;
        send_frame("045,120#");
        model_frame("045,120#");
        checks++;
        if (qv_count - q0 !== 1) begin
            errors++;
            $display("FAIL basic_pulses: got %0d required 1", qv_count - q0);
        end
        checks++;
        if (ang_w !== 12'h045 || dist_w !== 12'h120) begin
            errors++;
            $display("FAIL basic_digits: got %h/%h required 045/120", ang_w, dist_w);
        end
        checks++;
        if (ang_at_qv !== 12'h045 || dist_at_qv !== 12'h120) begin
            errors++;
            $display("FAIL basic_digits_at_pulse: got %h/%h required 045/120",
                     ang_at_qv, dist_at_qv);
        end
        checks++;
        if (bus.ameaca !== 1'b0 || bus.erro_quadro !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: got am=%b err=%b required 0 0",
                     bus.ameaca, bus.erro_quadro);
        end
    endtask

    task automatic test_ameaca();
        string fr[3] = '{"090,030#", "090,050#", "090,049#"};
        for (int k = 0; k < 3; k++) begin
            bit prev = m_ameaca;
            send_frame(fr[k]);
            model_frame(fr[k]);
            checks++;
            if (dist_w !== bcd3(m_dist)) begin
                errors++;
                $display("FAIL ameaca_digits %s: got %h required %h", fr[k], dist_w, bcd3(m_dist));
            end
            checks++;
            if (ameaca_at_qv !== prev || ameaca_after_qv !== m_ameaca) begin
                errors++;
                $display("FAIL ameaca_timing %s: got at=%b after=%b required %b %b",
                         fr[k], ameaca_at_qv, ameaca_after_qv, prev, m_ameaca);
            end
            checks++;
            if (bus.ameaca !== m_ameaca) begin
                errors++;
                $display("FAIL ameaca_value %s: got %b required %b", fr[k], bus.ameaca, m_ameaca);
            end
        end
    endtask

    task automatic test_bad_char();
        int q0 = qv_count;
        send_frame("12x,045#");
        model_frame("12x,045#");
        checks++;
        if (bus.erro_quadro !== 1'b1 || qv_count !== q0) begin
            errors++;
            $display("FAIL badchar_error: got err=%b pulses=%0d required 1 0",
                     bus.erro_quadro, qv_count - q0);
        end
        checks++;
        if (ang_w !== bcd3(m_ang) || dist_w !== bcd3(m_dist)) begin
            errors++;
            $display("FAIL badchar_hold: got %h/%h required %h/%h",
                     ang_w, dist_w, bcd3(m_ang), bcd3(m_dist));
        end
        send_frame("135,200#");
        model_frame("135,200#");
        checks++;
        if (ang_w !== 12'h135 || dist_w !== 12'h200 || bus.erro_quadro !== 1'b0) begin
            errors++;
            $display("FAIL badchar_recover: got %h/%h err=%b required 135/200 0",
                     ang_w, dist_w, bus.erro_quadro);
        end
    endtask

    task automatic test_stop_error();
        int q0 = qv_count;
        send_byte(8'h35, 1);
        repeat (2 * Clks) @(negedge clk);
        m_erro = 1'b1;
        checks++;
        if (bus.erro_quadro !== 1'b1 || bus.db_estado !== 4'd0) begin
            errors++;
            $display("FAIL stop_error: got err=%b st=%0d required 1 0",
                     bus.erro_quadro, bus.db_estado);
        end
        send_frame("077,310#");
        model_frame("077,310#");
        checks++;
        if (qv_count - q0 !== 1 || ang_w !== 12'h077 || dist_w !== 12'h310 ||
            bus.erro_quadro !== 1'b0) begin
            errors++;
            $display("FAIL stop_recover: got n=%0d %h/%h err=%b required 1 077/310 0",
                     qv_count - q0, ang_w, dist_w, bus.erro_quadro);
        end
    endtask

    task automatic test_glitch();
        int q0 = qv_count;
        bus.entrada_serial = 1'b0;
        repeat (3) @(negedge clk);
        bus.entrada_serial = 1'b1;
        repeat (2 * Clks) @(negedge clk);
        checks++;
        if (bus.erro_quadro !== m_erro || bus.db_estado !== 4'd0 || qv_count !== q0) begin
            errors++;
            $display("FAIL glitch: got err=%b st=%0d pulses=%0d required %b 0 0",
                     bus.erro_quadro, bus.db_estado, qv_count - q0, m_erro);
        end
    endtask

    // Back-to-back random frames, some with one position replaced by a letter.
    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            string s;
            s = $sformatf("%03d,%03d#", $urandom_range(0, 999), $urandom_range(0, 999));
            if ($urandom_range(0, 9) < 3) begin
                s.putc(int'($urandom_range(0, 7)), byte'(8'h41 + $urandom_range(0, 25)));
            end
            send_frame(s);
            model_frame(s);
            checks++;
            if (qv_count !== m_qv) begin
                errors++;
                $display("FAIL rand_pulses %s: got %0d required %0d", s, qv_count, m_qv);
            end
            checks++;
            if (ang_w !== bcd3(m_ang) || dist_w !== bcd3(m_dist)) begin
                errors++;
                $display("FAIL rand_digits %s: got %h/%h required %h/%h",
                         s, ang_w, dist_w, bcd3(m_ang), bcd3(m_dist));
            end
            checks++;
            if (bus.erro_quadro !== m_erro || bus.ameaca !== m_ameaca) begin
                errors++;
                $display("FAIL rand_flags %s: got err=%b am=%b required %b %b",
                         s, bus.erro_quadro, bus.ameaca, m_erro, m_ameaca);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame("123,456#");
        model_frame("123,456#");
        send_byte(8'h39, 0);
        send_byte(8'h38, 0);
        send_byte(8'h37, 0);
        send_byte(8'h2C, 0);
        bus.entrada_serial = 1'b0;
        repeat (3 * Clks) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ang_w, dist_w} !== 24'h0 || bus.ameaca !== 1'b0 || bus.erro_quadro !== 1'b0 ||
            bus.quadro_valido !== 1'b0 || bus.db_estado !== 4'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h/%h am=%b err=%b st=%0d required all 0",
                     ang_w, dist_w, bus.ameaca, bus.erro_quadro, bus.db_estado);
        end
        bus.entrada_serial = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        m_ang = 0; m_dist = 0; m_erro = 1'b0; m_ameaca = 1'b0;
        repeat (4) @(negedge clk);
        send_frame("250,075#");
        model_frame("250,075#");
        checks++;
        if (ang_w !== 12'h250 || dist_w !== 12'h075 || bus.erro_quadro !== 1'b0 ||
            bus.ameaca !== 1'b0) begin
            errors++;
            $display("FAIL midreset_recover: got %h/%h err=%b am=%b required 250/075 0 0",
                     ang_w, dist_w, bus.erro_quadro, bus.ameaca);
        end
    endtask

`ifdef TORRETA_RX_PARIDADE_EN
    task automatic test_parity();
        int q0 = qv_count;
        send_byte(8'h37, 2);
        repeat (2 * Clks) @(negedge clk);
        m_erro = 1'b1;
        checks++;
        if (bus.erro_quadro !== 1'b1 || qv_count !== q0 || bus.db_estado !== 4'd0) begin
            errors++;
            $display("FAIL parity_bad: got err=%b pulses=%0d st=%0d required 1 0 0",
                     bus.erro_quadro, qv_count - q0, bus.db_estado);
        end
        send_frame("300,010#");
        model_frame("300,010#");
        checks++;
        if (ang_w !== 12'h300 || dist_w !== 12'h010 || bus.erro_quadro !== 1'b0) begin
            errors++;
            $display("FAIL parity_recover: got %h/%h err=%b required 300/010 0",
                     ang_w, dist_w, bus.erro_quadro);
        end
    endtask
`endif

    initial begin
        bus.entrada_serial = 1'b1;
        test_reset();
        test_basic();
        test_ameaca();
        test_bad_char();
        test_stop_error();
        test_glitch();
        test_random();
        test_reset_mid_frame();
`ifdef TORRETA_RX_PARIDADE_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
